// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller: phase enum, LED
// patterns, 7-segment encodings and small BCD helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_LEFT   = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  localparam logic [4:0] LED_GREEN  = 5'b00011;
  localparam logic [4:0] LED_LEFT   = 5'b00100;
  localparam logic [4:0] LED_YELLOW = 5'b01000;
  localparam logic [4:0] LED_RED    = 5'b10000;

  localparam logic [6:0] SEG_DASH = 7'b011_1111;
  localparam logic [6:0] SEG_ZERO = 7'b100_0000;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b100_0000;
      4'h1:    return 7'b111_1001;
      4'h2:    return 7'b010_0100;
      4'h3:    return 7'b011_0000;
      4'h4:    return 7'b001_1001;
      4'h5:    return 7'b001_0010;
      4'h6:    return 7'b000_0010;
      4'h7:    return 7'b111_1000;
      4'h8:    return 7'b000_0000;
      4'h9:    return 7'b001_0000;
      4'hA:    return 7'b000_1000;
      4'hB:    return 7'b000_0011;
      4'hC:    return 7'b100_0110;
      4'hD:    return 7'b010_0001;
      4'hE:    return 7'b000_0110;
      default: return 7'b000_1110;
    endcase
  endfunction

  function automatic logic [4:0] led_of(input phase_e ph);
    case (ph)
      PH_GREEN:  return LED_GREEN;
      PH_LEFT:   return LED_LEFT;
      PH_YELLOW: return LED_YELLOW;
      default:   return LED_RED;
    endcase
  endfunction

  // Elaboration-time only: converts a duration parameter to packed BCD.
  function automatic logic [7:0] bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = v[7:4] - 4'd1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider producing a one-clock tick every DIV clocks; clr restarts the
// count so a phase always starts on a full tick period.
module tick_gen
  import traffic_pkg::*;
#(
  parameter int DIV = 25000000
) (
  input  logic CLK_50MHz,
  input  logic Res_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: assign a default first so every path writes cnt_d and no latch is inferred.
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  // NOTE: flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK_50MHz) begin
    if (!Res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/traffic_light_param.sv
// Parameterised three-road traffic light with BCD countdown and 7-segment display.
// Optional pedestrian shortening of GREEN is built when PED_REQ_EN is defined.
module traffic_light_param
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int T_GREEN  = 5,
  parameter int T_LEFT   = 4,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 14,
  parameter int PED_MIN  = 3
) (
  input  logic       CLK_50MHz,
  input  logic       Res_n,
  input  logic [2:0] Road_SW,
  input  logic       Ped_Req,
  output logic       Ped_Ack,
  output logic [4:0] LED,
  output logic [6:0] Seg4,
  output logic [6:0] Seg3,
  output logic [6:0] Seg2,
  output logic [6:0] Seg1,
  output logic       Counter
);

  if (T_GREEN < 1 || T_GREEN > 99 || T_LEFT < 1 || T_LEFT > 99 ||
      T_YELLOW < 1 || T_YELLOW > 99 || T_RED < 1 || T_RED > 99 ||
      PED_MIN < 1 || PED_MIN >= T_GREEN || TICK_DIV < 1) begin : g_bad_param
    $error("traffic_light_param: duration or PED_MIN parameter out of range");
  end

  // Phase states carry the phase index in [1:0] so the display needs no decode.
  localparam logic [2:0] S_GREEN  = {1'b0, PH_GREEN};
  localparam logic [2:0] S_LEFT   = {1'b0, PH_LEFT};
  localparam logic [2:0] S_YELLOW = {1'b0, PH_YELLOW};
  localparam logic [2:0] S_RED    = {1'b0, PH_RED};
  localparam logic [2:0] S_LOAD   = 3'b100;
  localparam logic [2:0] S_FLASH  = 3'b101;

  localparam logic [7:0] GREEN_BCD  = bcd8(T_GREEN);
  localparam logic [7:0] LEFT_BCD   = bcd8(T_LEFT);
  localparam logic [7:0] YELLOW_BCD = bcd8(T_YELLOW);
  localparam logic [7:0] RED_BCD    = bcd8(T_RED);

  function automatic logic [7:0] dur_of(input phase_e ph);
    case (ph)
      PH_GREEN:  return GREEN_BCD;
      PH_LEFT:   return LEFT_BCD;
      PH_YELLOW: return YELLOW_BCD;
      default:   return RED_BCD;
    endcase
  endfunction

  function automatic logic [2:0] start_of(input logic [2:0] road);
    case (road)
      3'b100:  return S_GREEN;
      3'b010:  return S_RED;
      default: return S_YELLOW;
    endcase
  endfunction

  logic [2:0] state_q, state_d, start_st;
  logic [7:0] rem_q, rem_d;
  logic [2:0] sw_q, sw_d;
  logic       flash_q, flash_d;
  logic       hb_q, hb_d;
  logic       tick, road_valid, ped_hit;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .CLK_50MHz (CLK_50MHz),
    .Res_n     (Res_n),
    .clr       (state_q == S_LOAD),
    .tick      (tick)
  );

  assign road_valid = $onehot(Road_SW);
  assign start_st   = start_of(Road_SW);

`ifdef PED_REQ_EN
  localparam logic [7:0] PED_BCD = bcd8(PED_MIN);
  logic ack_q, ack_d;
  assign ped_hit = Ped_Req && (state_q == S_GREEN) && (rem_q > PED_BCD);
`else
  localparam logic [7:0] PED_BCD = 8'h00;
  logic unused_ped_req;
  assign unused_ped_req = Ped_Req;
  assign ped_hit = 1'b0;
`endif

  // Priority: invalid road, LOAD exit, road change, then the phase tick.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sw_d    = Road_SW;
    flash_d = 1'b0;
    hb_d    = hb_q ^ tick;
`ifdef PED_REQ_EN
    ack_d   = 1'b0;
`endif
    if (!road_valid) begin
      state_d = S_FLASH;
      flash_d = (state_q == S_FLASH) ? (flash_q ^ tick) : 1'b0;
    end else if (state_q == S_LOAD) begin
      state_d = start_st;
      rem_d   = dur_of(phase_e'(start_st[1:0]));
    end else if (Road_SW != sw_q) begin
      state_d = S_LOAD;
    end else if (!state_q[2]) begin
      if (tick) begin
        if (ped_hit) begin
          rem_d = PED_BCD;
`ifdef PED_REQ_EN
          ack_d = 1'b1;
`endif
        end else if (rem_q == 8'h01) begin
          state_d = {1'b0, state_q[1:0] + 2'd1};
          rem_d   = dur_of(phase_e'(state_q[1:0] + 2'd1));
        end else begin
          rem_d = bcd_dec(rem_q);
        end
      end
    end else begin
      state_d = S_LOAD;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!Res_n) begin
      state_q <= S_LOAD;
      rem_q   <= 8'h00;
      sw_q    <= 3'b000;
      flash_q <= 1'b0;
      hb_q    <= 1'b0;
`ifdef PED_REQ_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sw_q    <= sw_d;
      flash_q <= flash_d;
      hb_q    <= hb_d;
`ifdef PED_REQ_EN
      ack_q   <= ack_d;
`endif
    end
  end

  // Display stage: registered copy of the decoded state, one clock behind it.
  logic [4:0] led_q, led_d;
  logic [6:0] seg4_q, seg4_d, seg3_q, seg3_d, seg2_q, seg2_d, seg1_q, seg1_d;
  logic [3:0] road_hex;

  always_comb begin
    led_d  = LED_RED;
    seg4_d = SEG_ZERO;
    seg3_d = SEG_ZERO;
    seg2_d = SEG_ZERO;
    seg1_d = SEG_ZERO;
    case (sw_q)
      3'b100:  road_hex = 4'hA;
      3'b010:  road_hex = 4'hB;
      default: road_hex = 4'hC;
    endcase
    if (state_q == S_FLASH) begin
      led_d  = {1'b0, flash_q, 3'b000};
      seg4_d = SEG_DASH;
      seg3_d = SEG_DASH;
      seg2_d = SEG_DASH;
      seg1_d = SEG_DASH;
    end else if (!state_q[2]) begin
      led_d  = led_of(phase_e'(state_q[1:0]));
      seg4_d = hex7(road_hex);
      seg3_d = hex7({2'b00, state_q[1:0]});
      seg2_d = hex7(rem_q[7:4]);
      seg1_d = hex7(rem_q[3:0]);
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (!Res_n) begin
      led_q  <= LED_RED;
      seg4_q <= SEG_ZERO;
      seg3_q <= SEG_ZERO;
      seg2_q <= SEG_ZERO;
      seg1_q <= SEG_ZERO;
    end else begin
      led_q  <= led_d;
      seg4_q <= seg4_d;
      seg3_q <= seg3_d;
      seg2_q <= seg2_d;
      seg1_q <= seg1_d;
    end
  end

`ifdef PED_REQ_EN
  logic ped_ack_q;
  always_ff @(posedge CLK_50MHz) begin
    if (!Res_n) ped_ack_q <= 1'b0;
    else        ped_ack_q <= ack_q;
  end
  assign Ped_Ack = ped_ack_q;
`else
  assign Ped_Ack = 1'b0;
`endif

  assign LED     = led_q;
  assign Seg4    = seg4_q;
  assign Seg3    = seg3_q;
  assign Seg2    = seg2_q;
  assign Seg1    = seg1_q;
  assign Counter = hb_q;

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed bench for traffic_light_param with TICK_DIV = 4; expected values are
// hand-derived clock by clock from the reset edge.
module tb_traffic_light_param;

  logic       clk = 1'b0;
  logic       res_n;
  logic [2:0] road_sw;
  logic       ped_req;
  logic       ped_ack;
  logic [4:0] led;
  logic [6:0] seg4, seg3, seg2, seg1;
  logic       counter;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] L_GREEN  = 5'b00011;
  localparam logic [4:0] L_LEFT   = 5'b00100;
  localparam logic [4:0] L_YELLOW = 5'b01000;
  localparam logic [4:0] L_RED    = 5'b10000;
  localparam logic [4:0] L_OFF    = 5'b00000;
  localparam logic [6:0] DASH     = 7'b011_1111;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  traffic_light_param #(
    .TICK_DIV (4),
    .T_GREEN  (5),
    .T_LEFT   (4),
    .T_YELLOW (2),
    .T_RED    (14),
    .PED_MIN  (3)
  ) dut (
    .CLK_50MHz (clk),
    .Res_n     (res_n),
    .Road_SW   (road_sw),
    .Ped_Req   (ped_req),
    .Ped_Ack   (ped_ack),
    .LED       (led),
    .Seg4      (seg4),
    .Seg3      (seg3),
    .Seg2      (seg2),
    .Seg1      (seg1),
    .Counter   (counter)
  );

  // Records any Ped_Ack pulse while a window is open.
  logic mon_ack  = 1'b0;
  logic ack_seen = 1'b0;
  always @(posedge clk) begin
    if (!mon_ack)     ack_seen <= 1'b0;
    else if (ped_ack) ack_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_digits(input string tag, input int rem);
    check({tag, ".digits"}, {25'd0, seg2, seg1}, {25'd0, seg_tab[rem / 10], seg_tab[rem % 10]});
  endtask

  task automatic check_phase(input string tag, input logic [4:0] exp_led, input int road,
                             input int ph, input int rem);
    check({tag, ".led"}, {27'd0, led}, {27'd0, exp_led});
    check({tag, ".road"}, {25'd0, seg4}, {25'd0, seg_tab[road]});
    check({tag, ".phase"}, {25'd0, seg3}, {25'd0, seg_tab[ph]});
    check_digits(tag, rem);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".led"}, {27'd0, led}, {27'd0, L_RED});
    check({tag, ".segs"}, {4'd0, seg4, seg3, seg2, seg1}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
    check({tag, ".counter"}, {31'd0, counter}, 32'd0);
    check({tag, ".ack"}, {31'd0, ped_ack}, 32'd0);
  endtask

  initial begin
    res_n   = 1'b0;
    road_sw = 3'b100;
    ped_req = 1'b0;
    @(negedge clk);
    check_reset("reset");
    res_n = 1'b1;

    // Road A: GREEN 5 ticks then LEFT.
    clk_n(2);
    check_phase("a_green", L_GREEN, 10, 0, 5);
    clk_n(2);
    check("hb_before_tick", {31'd0, counter}, 32'd0);
    check_digits("a_no_early_dec", 5);
    clk_n(1);
    check("hb_first_tick", {31'd0, counter}, 32'd1);
    clk_n(1);
    check_digits("a_first_dec", 4);
    clk_n(15);
    check_phase("a_green_last", L_GREEN, 10, 0, 1);
    clk_n(1);
    check_phase("a_left", L_LEFT, 10, 1, 4);

    // Road B: RED 14 with tens borrow.
    road_sw = 3'b010;
    clk_n(3);
    check_phase("b_red", L_RED, 11, 3, 14);
    for (int k = 1; k < 14; k++) begin
      clk_n(4);
      check_digits($sformatf("b_red_k%0d", k), 14 - k);
    end
    clk_n(3);
    check("b_red_hold.led", {27'd0, led}, {27'd0, L_RED});
    check_digits("b_red_hold", 1);
    clk_n(1);
    check_phase("b_green", L_GREEN, 11, 0, 5);

    // Road C: YELLOW then RED, then invalid select to FLASH.
    road_sw = 3'b001;
    clk_n(3);
    check_phase("c_yellow", L_YELLOW, 12, 2, 2);
    clk_n(8);
    check_phase("c_red", L_RED, 12, 3, 14);
    clk_n(4);
    check_digits("c_red_13", 13);
    road_sw = 3'b011;
    clk_n(2);
    check("flash_led0", {27'd0, led}, {27'd0, L_OFF});
    check("flash_segs", {4'd0, seg4, seg3, seg2, seg1}, {4'd0, DASH, DASH, DASH, DASH});
    clk_n(1);
    check("flash_led_pre", {27'd0, led}, {27'd0, L_OFF});
    clk_n(1);
    check("flash_led1", {27'd0, led}, {27'd0, L_YELLOW});
    clk_n(3);
    check("flash_led1_hold", {27'd0, led}, {27'd0, L_YELLOW});
    clk_n(1);
    check("flash_led2", {27'd0, led}, {27'd0, L_OFF});
    clk_n(4);
    check("flash_led3", {27'd0, led}, {27'd0, L_YELLOW});
    road_sw = 3'b001;
    clk_n(3);
    check_phase("unflash_yellow", L_YELLOW, 12, 2, 2);

    // Road change on the same clock as a tick.
    clk_n(2);
    road_sw = 3'b100;
    clk_n(1);
    check_digits("sw_tick_pre", 2);
    clk_n(2);
    check_phase("sw_tick_green", L_GREEN, 10, 0, 5);

    ped_req = 1'b1;
`ifdef PED_REQ_EN
    clk_n(3);
    check("ped_ack_early", {31'd0, ped_ack}, 32'd0);
    clk_n(1);
    check("ped_ack_pulse", {31'd0, ped_ack}, 32'd1);
    check_digits("ped_load", 3);
    clk_n(1);
    check("ped_ack_end", {31'd0, ped_ack}, 32'd0);
    clk_n(3);
    check_digits("ped_no_reload", 2);
    check("ped_ack_min", {31'd0, ped_ack}, 32'd0);
    clk_n(8);
    check_phase("ped_left", L_LEFT, 10, 1, 4);
    ped_req = 1'b0;
    clk_n(1);
    res_n = 1'b0;
    clk_n(1);
    check_reset("mid_left_reset");
    res_n = 1'b1;
    clk_n(2);
    check_phase("after_reset", L_GREEN, 10, 0, 5);
    clk_n(45);
    check_phase("ped_red", L_RED, 10, 3, 14);
    ped_req = 1'b1;
    mon_ack = 1'b1;
    clk_n(16);
    check("ped_red_no_ack", {31'd0, ack_seen}, 32'd0);
    check_phase("ped_red_10", L_RED, 10, 3, 10);
    mon_ack = 1'b0;
    ped_req = 1'b0;
`else
    mon_ack = 1'b1;
    clk_n(4);
    check_digits("noped_dec", 4);
    clk_n(15);
    check_phase("noped_green_last", L_GREEN, 10, 0, 1);
    clk_n(1);
    check_phase("noped_left", L_LEFT, 10, 1, 4);
    check("noped_no_ack", {31'd0, ack_seen}, 32'd0);
    mon_ack = 1'b0;
    ped_req = 1'b0;
    clk_n(1);
    res_n = 1'b0;
    clk_n(1);
    check_reset("mid_left_reset");
    res_n = 1'b1;
    clk_n(2);
    check_phase("after_reset", L_GREEN, 10, 0, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
